// File: rtl/seg7_scan_scheduler_if.sv
// Display-scan bus: value inputs from the counter logic and pin-side outputs.
interface seg7_scan_scheduler_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  EN;
    logic [4*DIGITS-1:0]   DATA;
    logic [DIGITS-1:0]     DP;
    logic [DIGITS-1:0]     DIG_EN;
    logic                  LZB;
    logic [6:0]            SEG;
    logic                  DP_OUT;
    logic [DIGITS-1:0]     AN;
    logic                  FRAME;

    // Value side drives the controls and observes the pins.
    modport master (
        output EN, DATA, DP, DIG_EN, LZB,
        input  SEG, DP_OUT, AN, FRAME
    );

    // Scheduler side.
    modport slave (
        input  EN, DATA, DP, DIG_EN, LZB,
        output SEG, DP_OUT, AN, FRAME
    );
endinterface

// File: rtl/seg7_scan_scheduler.sv
// Time-multiplexes a shared 7-segment bus across DIGITS common-anode digits.
// Each digit gets a fixed DIV-cycle slot: BLANK_CYC cycles dark, then driven.
module seg7_scan_scheduler #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DIV       = 10000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    seg7_scan_scheduler_if.slave  bus
);
    localparam int unsigned PC_W  = $clog2(DIV);
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned DAT_W = 4 * DIGITS;

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic [DIGITS-1:0]  dp_q, dp_d;
    logic [DIGITS-1:0]  den_q, den_d;
    logic               frame_q, frame_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dpo_q, dpo_d;

    logic [DIGITS-1:0]  lz_mask;
    logic [3:0]         sel_nib;
    logic               sel_dp;
    logic               sel_den;
    logic               sel_lz;
    logic               run;

    // Hex to gfedcba, active-low.
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // Scan sequencing: prescaler, digit index, frame latch and frame pulse.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        dp_d    = dp_q;
        den_d   = den_q;
        frame_d = 1'b0;
        if (!bus.EN) begin
            state_d = S_OFF;
            pc_d    = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_BLANK;
                    pc_d    = '0;
                    idx_d   = '0;
                    frame_d = 1'b1;
                    dat_d   = bus.DATA;
                    dp_d    = bus.DP;
                    den_d   = bus.DIG_EN;
                end
                S_BLANK: begin
                    pc_d = pc_q + PC_W'(1);
                    if (pc_q == PC_W'(BLANK_CYC - 1)) begin
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (pc_q == PC_W'(DIV - 1)) begin
                        pc_d    = '0;
                        state_d = S_BLANK;
                        if (idx_q == IDX_W'(DIGITS - 1)) begin
                            idx_d   = '0;
                            frame_d = 1'b1;
                            dat_d   = bus.DATA;
                            dp_d    = bus.DP;
                            den_d   = bus.DIG_EN;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
                default: begin
                    state_d = S_OFF;
                    pc_d    = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Leading-zero mask: a zero run from the top, broken by any non-zero nibble or lit DP.
    always_comb begin
        lz_mask = '0;
        run     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run        = run & (dat_d[4*i +: 4] == 4'h0) & ~dp_d[i];
            lz_mask[i] = run & bus.LZB & (i != 0);
        end
    end

    // Next pin values for the state being entered; dark unless an unsuppressed SHOW.
    always_comb begin
        sel_nib = 4'h0;
        sel_dp  = 1'b0;
        sel_den = 1'b0;
        sel_lz  = 1'b0;
        an_d    = '1;
        seg_d   = 7'h7F;
        dpo_d   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_nib = dat_d[4*i +: 4];
                sel_dp  = dp_d[i];
                sel_den = den_d[i];
                sel_lz  = lz_mask[i];
            end
        end
        if (state_d == S_SHOW && sel_den && !sel_lz) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_d == IDX_W'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
            seg_d = decode(sel_nib);
            dpo_d = ~sel_dp;
        end
    end

    // State, latches and registered pins.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_OFF;
            pc_q    <= '0;
            idx_q   <= '0;
            dat_q   <= '0;
            dp_q    <= '0;
            den_q   <= '0;
            frame_q <= 1'b0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dpo_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            dp_q    <= dp_d;
            den_q   <= den_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dpo_q   <= dpo_d;
        end
    end

    assign bus.AN     = an_q;
    assign bus.SEG    = seg_q;
    assign bus.DP_OUT = dpo_q;
    assign bus.FRAME  = frame_q;
endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Bench for seg7_scan_scheduler: time-indexed display model plus directed checkpoints.
module tb_seg7_scan_scheduler;
    localparam int DIGITS    = 4;
    localparam int DIV       = 8;
    localparam int BLANK     = 2;
    localparam int FRAME_LEN = DIGITS * DIV;

    logic clk;
    logic rst_n;

    seg7_scan_scheduler_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_scheduler #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .CLK  (clk),
        .RSTN (rst_n),
        .bus  (bus)
    );

    always begin
        clk = 1'b0;
        #12;
        clk = 1'b1;
        #13;
    end

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int vectors    = 0;
    int miscompares = 0;

    // Model: running flag and cycle count since the display was switched on.
    bit         m_run = 1'b0;
    int         m_t   = 0;
    bit         m_lzb = 1'b0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp   = '0;
    logic [3:0]  m_den  = '0;

    function automatic bit lz_blank(input int s);
        if (!m_lzb || s == 0) return 1'b0;
        for (int j = s; j < DIGITS; j++) begin
            if (m_data[4*j +: 4] != 4'h0 || m_dp[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dpo;
        logic       e_fr;
        int         slot;
        int         phase;
        slot  = (m_t / DIV) % DIGITS;
        phase = m_t % DIV;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dpo = 1'b1;
        e_fr  = m_run && (m_t % FRAME_LEN == 0);
        if (m_run && phase >= BLANK && m_den[slot] && !lz_blank(slot)) begin
            e_an[slot] = 1'b0;
            e_seg      = seg_tab[m_data[4*slot +: 4]];
            e_dpo      = ~m_dp[slot];
        end
        vectors++;
        if (bus.AN !== e_an || bus.SEG !== e_seg || bus.DP_OUT !== e_dpo || bus.FRAME !== e_fr) begin
            miscompares++;
            $display("FAIL cycle t=%0d: got an=%b seg=%b dp=%b fr=%b want an=%b seg=%b dp=%b fr=%b",
                     m_t, bus.AN, bus.SEG, bus.DP_OUT, bus.FRAME, e_an, e_seg, e_dpo, e_fr);
        end
        vectors++;
        if ($countones(~bus.AN) > 1) begin
            miscompares++;
            $display("FAIL an_onehot: got an=%b want at most one low", bus.AN);
        end
    endtask

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            m_run  = 1'b0;
            m_t    = 0;
            m_data = '0;
            m_dp   = '0;
            m_den  = '0;
        end else if (!bus.EN) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run  = 1'b1;
            m_t    = 0;
            m_data = bus.DATA;
            m_dp   = bus.DP;
            m_den  = bus.DIG_EN;
        end else begin
            m_t++;
            if (m_t % FRAME_LEN == 0) begin
                m_data = bus.DATA;
                m_dp   = bus.DP;
                m_den  = bus.DIG_EN;
            end
        end
        m_lzb = bus.LZB;
        @(negedge clk);
        compare();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int cnt;
        rst_n      = 1'b0;
        bus.EN     = 1'b1;
        bus.DATA   = 16'h1234;
        bus.DP     = 4'h0;
        bus.DIG_EN = 4'hF;
        bus.LZB    = 1'b0;
        @(negedge clk);

        // Reset held with EN high: dark.
        step_n(3);
        chk("rst_an", int'(bus.AN), 4'hF);
        chk("rst_seg", int'(bus.SEG), 7'h7F);
        chk("rst_frame", int'(bus.FRAME), 0);

        // Release: frame pulse, 2-cycle blank, digit 0 shows '4'.
        rst_n = 1'b1;
        step();
        chk("start_frame", int'(bus.FRAME), 1);
        chk("start_an0", int'(bus.AN), 4'hF);
        step();
        chk("start_an1", int'(bus.AN), 4'hF);
        step();
        chk("d0_an", int'(bus.AN), 4'b1110);
        chk("d0_seg", int'(bus.SEG), 7'b0011001);
        step_n(8);
        chk("d1_an", int'(bus.AN), 4'b1101);
        chk("d1_seg", int'(bus.SEG), 7'b0110000);
        step_n(8);
        chk("d2_seg", int'(bus.SEG), 7'b0100100);
        step_n(8);
        chk("d3_an", int'(bus.AN), 4'b0111);
        chk("d3_seg", int'(bus.SEG), 7'b1111001);
        step_n(6);
        chk("frame2", int'(bus.FRAME), 1);

        // Data change in digit-2 slot does not tear the frame.
        step_n(16);
        bus.DATA = 16'hFFFF;
        step_n(4);
        chk("tear_d2", int'(bus.SEG), 7'b0100100);
        step_n(8);
        chk("tear_d3", int'(bus.SEG), 7'b1111001);
        step_n(6);
        chk("newf_d0", int'(bus.SEG), 7'b0001110);

        // Leading-zero blanking on 0050.
        step_n(24);
        bus.DATA = 16'h0050;
        bus.LZB  = 1'b1;
        step_n(8);
        chk("lz_d0_an", int'(bus.AN), 4'b1110);
        chk("lz_d0_seg", int'(bus.SEG), 7'b1000000);
        step_n(8);
        chk("lz_d1_seg", int'(bus.SEG), 7'b0010010);
        step_n(8);
        chk("lz_d2_an", int'(bus.AN), 4'hF);
        step_n(8);
        chk("lz_d3_an", int'(bus.AN), 4'hF);
        bus.DP = 4'b0100;
        step_n(24);
        chk("lzdp_d2_an", int'(bus.AN), 4'b1011);
        chk("lzdp_d2_seg", int'(bus.SEG), 7'b1000000);
        chk("lzdp_d2_dp", int'(bus.DP_OUT), 0);
        step_n(8);
        chk("lzdp_d3_an", int'(bus.AN), 4'hF);

        // Digit mask: digit 2 dark, frame period unchanged.
        bus.DP     = 4'h0;
        bus.LZB    = 1'b0;
        bus.DATA   = 16'h1234;
        bus.DIG_EN = 4'b1011;
        step_n(24);
        chk("mask_d2_an", int'(bus.AN), 4'hF);
        chk("mask_d2_seg", int'(bus.SEG), 7'h7F);
        cnt = 0;
        while (!bus.FRAME && cnt < 40) begin
            step();
            cnt++;
        end
        chk("frame_found", cnt, 14);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!bus.FRAME && cnt < 40);
        chk("frame_period", cnt, 32);

        // EN dropped mid digit-1 slot, restored 10 cycles later.
        step_n(13);
        chk("pre_drop_an", int'(bus.AN), 4'b1101);
        bus.EN = 1'b0;
        step();
        chk("drop_an", int'(bus.AN), 4'hF);
        chk("drop_frame", int'(bus.FRAME), 0);
        step_n(9);
        bus.EN = 1'b1;
        step();
        chk("restart_frame", int'(bus.FRAME), 1);
        chk("restart_an", int'(bus.AN), 4'hF);
        step();
        chk("restart_blank", int'(bus.AN), 4'hF);
        step();
        chk("restart_d0", int'(bus.AN), 4'b1110);

        // Asynchronous reset mid-SHOW, between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_an", int'(bus.AN), 4'hF);
        chk("arst_seg", int'(bus.SEG), 7'h7F);
        chk("arst_dp", int'(bus.DP_OUT), 1);
        chk("arst_frame", int'(bus.FRAME), 0);
        step_n(2);
        rst_n = 1'b1;
        step_n(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
